// File: rtl/apb2apb_bridge_pkg.sv
// Shared types and constants for the request-to-APB-to-memory bridge.
package apb2apb_bridge_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int MEM_WORDS  = 256;

    // Highest legal address (exclusive) in units of each access size
    localparam int LIMIT_FULLWORD = MEM_WORDS;
    localparam int LIMIT_HALFWORD = MEM_WORDS * 2;
    localparam int LIMIT_BYTE     = MEM_WORDS * 4;

    typedef enum logic [1:0] {
        FULLWORD = 2'd0,
        HALFWORD = 2'd1,
        BYTE     = 2'd2
    } dsel_type;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } master_state_e;

endpackage

// File: rtl/apb2mem_slave.sv
// APB slave fronting a word-organised memory: one wait state, size-scaled
// address decode, range check and byte-lane steering.
module apb2mem_slave
    import apb2apb_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [1:0]            psize,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [BE_WIDTH-1:0]   mem_be,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    logic                  wait_done;
    logic                  addr_ok;
    logic                  strobe;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [BE_WIDTH-1:0]   lane_be;
    logic [4:0]            lane_shift;
    logic [DATA_WIDTH-1:0] lane_mask;

    // wait_done marks the second ACCESS cycle; it self-clears so pready is one cycle wide
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_done <= 1'b0;
        end else begin
            wait_done <= psel & penable & ~wait_done;
        end
    end

    assign pready = psel & penable & wait_done;

    always_comb begin
        word_idx   = paddr;
        lane_be    = '1;
        lane_shift = 5'd0;
        lane_mask  = '1;
        addr_ok    = paddr < ADDR_WIDTH'(LIMIT_FULLWORD);
        case (psize)
            HALFWORD: begin
                word_idx   = paddr >> 1;
                lane_be    = paddr[0] ? 4'b1100 : 4'b0011;
                lane_shift = {paddr[0], 4'b0000};
                lane_mask  = DATA_WIDTH'(32'h0000_FFFF);
                addr_ok    = paddr < ADDR_WIDTH'(LIMIT_HALFWORD);
            end
            BYTE: begin
                word_idx   = paddr >> 2;
                lane_be    = BE_WIDTH'(1) << paddr[1:0];
                lane_shift = {paddr[1:0], 3'b000};
                lane_mask  = DATA_WIDTH'(32'h0000_00FF);
                addr_ok    = paddr < ADDR_WIDTH'(LIMIT_BYTE);
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so a reset landing on the ready cycle aborts the write
    assign strobe      = pready & addr_ok & rst_n;
    assign pslverr     = pready & ~addr_ok;
    assign mem_wr      = strobe & pwrite;
    assign mem_rd      = strobe & ~pwrite;
    assign mem_be      = strobe ? lane_be : '0;
    assign mem_address = strobe ? word_idx : '0;
    assign mem_data_in = strobe ? ((pwdata & lane_mask) << lane_shift) : '0;
    assign prdata      = (mem_data_out >> lane_shift) & lane_mask;

endmodule

// File: rtl/apb2apb_bridge.sv
// Request front end driving an internal APB master; each request becomes one
// SETUP/ACCESS transfer to the memory-facing APB slave.
module apb2apb_bridge
    import apb2apb_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            dsel,
    input  logic                  trnsfr,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [BE_WIDTH-1:0]   mem_be,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output master_state_e         dbg_state
);

    master_state_e         state_q, state_d;
    logic                  capture;
    logic [1:0]            size_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  psel, penable, pwrite, pready, pslverr;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata, prdata;
    logic [1:0]            psize;
    logic                  read_done;
    logic [DATA_WIDTH-1:0] read_value;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (trnsfr) begin
                    state_d = SETUP;
                    capture = 1'b1;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d = trnsfr ? SETUP : IDLE;
                    capture = trnsfr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign psel       = (state_q != IDLE);
    assign penable    = (state_q == ACCESS);
    assign pwrite     = wr_q;
    assign paddr      = addr_q;
    assign pwdata     = wdata_q;
    assign psize      = size_q;
    assign dbg_state  = state_q;

    // Read data is visible combinationally in its ready cycle, then held
    assign read_done  = psel & penable & pready & ~pwrite & rst_n;
    assign read_value = pslverr ? '0 : prdata;
    assign data_out   = read_done ? read_value : rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            size_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                size_q  <= dsel;
                wr_q    <= wr;
                addr_q  <= address;
                wdata_q <= data_in;
            end
            if (read_done) begin
                rdata_q <= read_value;
            end
        end
    end

    apb2mem_slave u_slave (
        .clk          (clk),
        .rst_n        (rst_n),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .psize        (psize),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_be       (mem_be),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

endmodule

// File: tb/tb_apb2apb_bridge.sv
// Bench for apb2apb_bridge: external 256-word memory, transaction-level
// reference model with per-cycle compare, and directed literal checks.
module tb_apb2apb_bridge;
    import apb2apb_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  dsel;
    logic        trnsfr, wr;
    logic [31:0] address, data_in, data_out;
    logic        mem_wr, mem_rd;
    logic [3:0]  mem_be;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    master_state_e dbg_state;

    always #5 clk = ~clk;

    apb2apb_bridge dut (
        .clk(clk), .rst_n(rst_n), .dsel(dsel), .trnsfr(trnsfr), .wr(wr),
        .address(address), .data_in(data_in), .data_out(data_out),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_be(mem_be),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .dbg_state(dbg_state)
    );

    // External memory: asynchronous read, byte-enabled write at the edge ending the strobe
    logic [31:0] mem [0:255];
    assign mem_data_out = (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_wr)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_address[7:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-address arithmetic straight from the size rules
    function automatic void decode(input logic [1:0] sz, input logic [31:0] a,
                                   output bit ok, output int word, output int shift,
                                   output logic [31:0] mask, output logic [3:0] be);
        int nbytes;
        longint byte_addr;
        nbytes    = (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
        byte_addr = longint'(a) * nbytes;
        ok        = byte_addr < 1024;
        word      = int'(byte_addr / 4);
        shift     = int'(byte_addr % 4) * 8;
        mask      = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        be        = 4'((((1 << nbytes) - 1) << int'(byte_addr % 4)));
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    logic [31:0] ref_mem [0:255];
    int          cyc = 0;
    bit          pend_v = 0;
    int          pend_fire, pend_end, pend_word;
    bit          pend_w, pend_ok;
    logic [31:0] pend_din, pend_rdata;
    logic [3:0]  pend_be;
    logic [31:0] exp_data = '0;

    always @(posedge clk) begin
        int sh;
        logic [31:0] msk;
        cyc++;
        if (!rst_n) begin
            pend_v   = 0;
            exp_data = '0;
        end else begin
            if (pend_v && cyc == pend_end) begin
                if (!pend_w) exp_data = pend_rdata;
                else if (pend_ok)
                    ref_mem[pend_word] = (ref_mem[pend_word] & ~be_mask(pend_be)) | pend_din;
                pend_v = 0;
            end
            if (!pend_v && trnsfr) begin
                decode(dsel, address, pend_ok, pend_word, sh, msk, pend_be);
                pend_w     = wr;
                pend_din   = (data_in & msk) << sh;
                pend_rdata = '0;
                if (pend_ok) pend_rdata = (ref_mem[pend_word] >> sh) & msk;
                pend_fire  = cyc + 2;
                pend_end   = cyc + 3;
                pend_v     = 1;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_mem_wr", mem_wr, 0);
            check("rst_mem_rd", mem_rd, 0);
            check("rst_mem_be", mem_be, 0);
        end else if (pend_v && cyc == pend_fire) begin
            check("strobe_wr", mem_wr, pend_w & pend_ok);
            check("strobe_rd", mem_rd, !pend_w & pend_ok);
            check("strobe_be", mem_be, pend_ok ? pend_be : 4'h0);
            if (pend_ok) check("strobe_addr", mem_address, pend_word);
            if (pend_ok && pend_w) check("strobe_wdata", mem_data_in, pend_din);
            check("strobe_dout", data_out, pend_w ? exp_data : pend_rdata);
        end else begin
            check("idle_mem_wr", mem_wr, 0);
            check("idle_mem_rd", mem_rd, 0);
            check("idle_mem_be", mem_be, 0);
            check("idle_dout", data_out, exp_data);
        end
    end

    // Scoreboard of expected read data in completion order
    logic [31:0] exp_q[$];
    bit          collect = 0;
    int          wr_cnt = 0, rd_cnt = 0;
    always @(negedge clk) begin
        if (mem_wr) wr_cnt++;
        if (mem_rd) rd_cnt++;
        if (collect && mem_rd) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL seq_rd: got 0x%08h, expected nothing queued", data_out);
            end else begin
                check("seq_rd", data_out, exp_q.pop_front());
            end
        end
    end

    logic        s_wr, s_rd, s_pready, s_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_din, s_dout;

    // One transfer; entered and left #1 after a rising edge, snapshots the ready cycle
    task automatic xfer(input logic [1:0] sz, input logic w, input logic [31:0] a, input logic [31:0] d);
        dsel = sz; wr = w; address = a; data_in = d; trnsfr = 1'b1;
        @(posedge clk); #1;
        trnsfr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s_wr = mem_wr; s_rd = mem_rd; s_be = mem_be; s_addr = mem_address;
        s_din = mem_data_in; s_dout = data_out;
        s_pready = dut.pready; s_err = dut.pslverr;
        @(posedge clk); #1;
    endtask

    task automatic burst(input logic [1:0] sz, input logic w, input logic [31:0] base,
                         input int n, input logic [31:0] dbase);
        dsel = sz; wr = w; address = base; data_in = dbase; trnsfr = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == n - 1) trnsfr = 1'b0;
            else begin
                address = base + 32'(i + 1);
                data_in = dbase + 32'(i + 1);
            end
            repeat (2) @(posedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0]  esz [3];
        logic [31:0] ea  [3];
        int w0, r0;
        esz = '{2'd0, 2'd1, 2'd2};
        ea  = '{32'h100, 32'h200, 32'h400};
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst_n = 1'b0; trnsfr = 1'b0; wr = 1'b0; dsel = 2'd0; address = '0; data_in = '0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_dout", data_out, 0);
        check("reset_mem_addr", mem_address, 0);
        check("reset_mem_din", mem_data_in, 0);
        check("reset_state", dbg_state, IDLE);
        @(posedge clk); #1;

        xfer(2'd0, 1'b1, 32'hF0, 32'h000A3210);
        check("fw_wr_strobe", s_wr, 1);
        check("fw_wr_addr", s_addr, 32'hF0);
        check("fw_wr_be", s_be, 4'b1111);
        check("fw_wr_din", s_din, 32'h000A3210);
        xfer(2'd0, 1'b0, 32'hF0, 32'h0);
        check("fw_rd_strobe", s_rd, 1);
        check("fw_rd_dout", s_dout, 32'h000A3210);

        xfer(2'd1, 1'b1, 32'h12, 32'h510FCB29);
        check("hw_wr_addr", s_addr, 32'h09);
        check("hw_wr_be", s_be, 4'b0011);
        check("hw_wr_din", s_din, 32'h0000CB29);
        xfer(2'd1, 1'b0, 32'h12, 32'h0);
        check("hw_rd_dout", s_dout, 32'h0000CB29);
        xfer(2'd1, 1'b1, 32'h13, 32'h00001234);
        check("hw_hi_be", s_be, 4'b1100);
        check("hw_hi_din", s_din, 32'h12340000);

        xfer(2'd2, 1'b1, 32'h3D, 32'h01021034);
        check("b_wr_addr", s_addr, 32'h0F);
        check("b_wr_be", s_be, 4'b0010);
        check("b_wr_din", s_din, 32'h00003400);
        xfer(2'd2, 1'b0, 32'h3D, 32'h0);
        check("b_rd_dout", s_dout, 32'h00000034);

        for (int k = 0; k < 3; k++) begin
            xfer(esz[k], 1'b1, ea[k], 32'hFFFFFFFF);
            check("err_wr_pready", s_pready, 1);
            check("err_wr_pslverr", s_err, 1);
            check("err_wr_strobe", {s_wr, s_rd}, 0);
            check("err_wr_be", s_be, 0);
            xfer(esz[k], 1'b0, ea[k], 32'h0);
            check("err_rd_pready", s_pready, 1);
            check("err_rd_strobe", {s_wr, s_rd}, 0);
            check("err_rd_dout", s_dout, 0);
        end

        xfer(2'd3, 1'b1, 32'h20, 32'hDEADBEEF);
        check("dsel3_be", s_be, 4'b1111);
        check("dsel3_addr", s_addr, 32'h20);

        w0 = wr_cnt;
        burst(2'd0, 1'b1, 32'hB0, 8, 32'hC0D942F0);
        check("burst_wr_count", wr_cnt - w0, 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0D942F0 + 32'(i));
        collect = 1;
        r0 = rd_cnt;
        burst(2'd0, 1'b0, 32'hB0, 8, 32'h0);
        check("burst_rd_count", rd_cnt - r0, 8);

        xfer(2'd0, 1'b1, 32'h90, 32'hFBED4C97);
        exp_q.push_back(32'h97); exp_q.push_back(32'h4C);
        exp_q.push_back(32'hED); exp_q.push_back(32'hFB);
        burst(2'd2, 1'b0, 32'h240, 4, 32'h0);
        collect = 0;
        check("exp_q_drained", exp_q.size(), 0);

        // Reset lands on the ready cycle of a write: no strobe, read data cleared
        dsel = 2'd0; wr = 1'b1; address = 32'h05; data_in = 32'h55AA55AA; trnsfr = 1'b1;
        @(posedge clk); #1;
        trnsfr = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b0;
        w0 = wr_cnt;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_write", wr_cnt - w0, 0);
        check("abort_dout", data_out, 0);
        check("abort_state", dbg_state, IDLE);
        @(posedge clk); #1;
        xfer(2'd0, 1'b0, 32'h05, 32'h0);
        check("abort_mem_untouched", s_dout, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb2apb_bridge.md
# apb2apb_bridge

Two-stage APB bridge between a simple transfer-request front end and a word-organised, byte-enabled memory port. An internal APB master converts each request (full-word, half-word or byte) into an APB SETUP/ACCESS transfer. An internal APB slave decodes the size-scaled address, range-checks it, and drives a 256 × 32-bit memory with word address, byte enables and lane-aligned data. The memory model itself is external.

## Interface
- ADDR_WIDTH, 32, request and memory address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8 = 4
- MEM_WORDS, 256, memory depth in words (1 KB)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; synchronous and active-low
- dsel  in  2  access size: FULLWORD=0, HALFWORD=1, BYTE=2 (3 is treated as FULLWORD)
- trnsfr  in  1  transfer request; held high for back-to-back transfers
- wr  in  1  1 = write, 0 = read
- address  in  ADDR_WIDTH  address in units of the access size
- data_in  in  DATA_WIDTH  write data, right-aligned
- data_out  out  DATA_WIDTH  read data, right-aligned and zero-extended
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_be  out  4  byte enables
- mem_address  out  ADDR_WIDTH  word index
- mem_data_in  out  DATA_WIDTH  lane-aligned write data
- mem_data_out  in  DATA_WIDTH  memory read word (asynchronous read of mem_address)

## Operation
- Master FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP when trnsfr=1. On entry, capture dsel, wr, address and data_in.
  - SETUP → ACCESS unconditionally.
  - ACCESS holds until pready. Then go to SETUP (re-capture inputs) if trnsfr=1, else IDLE.
- Slave behaviour:
  - Inserts exactly one wait state: pready=0 in the first ACCESS cycle, 1 in the second.
  - pready is a one-cycle pulse.
- Address decode, with A = captured address:
  - FULLWORD: word A, mem_be 1111, valid when A < 256.
  - HALFWORD: word A>>1, lane A[0], mem_be 0011 or 1100, valid when A < 512.
  - BYTE: word A>>2, lane A[1:0], mem_be 0001 << A[1:0], valid when A < 1024.
- Valid access:
  - In the pready cycle only, assert mem_wr (write) or mem_rd (read) with mem_address, mem_be and mem_data_in.
  - mem_data_in carries the data shifted to its lane, with other lanes zero.
- Invalid access:
  - pslverr=1 (internal), with pready still pulsed.
  - mem_wr, mem_rd and mem_be stay 0.
  - A read returns data_out = 0.
- Read data:
  - The selected lane of mem_data_out is right-aligned and zero-extended.
  - It is driven on data_out combinationally during the pready cycle, then held in a register until the next read completes.
- Writes do not change data_out.

## Timing
- Reset: FSM to IDLE. data_out, mem_wr, mem_rd, mem_be, mem_address and mem_data_in are all 0.
- Reset asserted mid-transfer aborts the transfer with no memory strobe.
- Request sampled at edge t: SETUP t+1, ACCESS-wait t+2, ACCESS-ready (strobe, data_out valid) t+3.
- Back-to-back throughput is 3 cycles per transfer while trnsfr stays high. The next address/data are sampled on the edge that leaves ACCESS.
- trnsfr dropping during SETUP or ACCESS does not cancel the current transfer.
- Memory write occurs on the clock edge that ends the strobe cycle.

## Structure
- Shared package: dsel_type enum, ADDR_WIDTH, DATA_WIDTH, MEM_WORDS, and per-size address limits.
- Internal APB signals: psel, penable, pwrite, paddr, pwdata, psize, prdata, pready, pslverr.
- One natural sub-module, apb2mem_slave: decode, range check, lane steering, wait state.
- The master FSM lives in the top level.

## Test plan
- FULLWORD write 0xF0 with 0x000A3210, then read 0xF0:
  - Write: mem_wr pulse, mem_address 0xF0, mem_be 1111.
  - Read: data_out 0x000A3210.
- HALFWORD write 0x12 with 0x510FCB29:
  - mem_address 0x09, mem_be 0011, mem_data_in 0x0000CB29.
  - Read 0x12 returns 0x0000CB29. Address 0x13 uses mem_be 1100.
- BYTE write 0x3D with 0x01021034:
  - mem_address 0x0F, mem_be 0010, mem_data_in 0x00003400.
  - Read 0x3D returns 0x00000034.
- Error cases: FULLWORD 0x100, HALFWORD 0x200, BYTE 0x400 (write and read):
  - pready pulses, no mem_wr or mem_rd.
  - Read data_out is 0.
- Burst with trnsfr held: FULLWORD writes 0xB0..0xB7 of 0xC0D942F0+i, one strobe every 3 cycles.
  - Burst read returns the same values in order.
- FULLWORD write 0x90 with 0xFBED4C97, then BYTE reads 0x240..0x243:
  - Returns 0x97, 0x4C, 0xED, 0xFB.
